// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Scoreboard entries are sized for the widest supported register address.
package pipe_pkg;

    localparam int MAX_AW = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] waddr;
        logic              is_load;
    } sb_entry_t;

    function automatic int sel_w(input int track);
        return $clog2(track + 1);
    endfunction

    // Load data must become forwardable before it leaves the tracked window.
    function automatic bit load_lat_ok(input int lat, input int track);
        return (lat >= 1) && (lat <= track - 1);
    endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// Priority match of one ID source against the scoreboard slots.
// Reports the youngest producer and whether it is a load still too young to forward.
module hazard_fwd_match
    import pipe_pkg::*;
#(
    parameter int TRACK    = 3,
    parameter int AW       = 8,
    parameter int SEL_W    = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic [AW-1:0]       src_addr_i,
    input  logic                src_used_i,
    input  logic [TRACK-1:0]    slot_valid_i,
    input  logic [TRACK*AW-1:0] slot_waddr_i,
    input  logic [TRACK-1:0]    slot_load_i,
    output logic [SEL_W-1:0]    sel_o,
    output logic                load_hit_o
);

    // Scan oldest to youngest so the youngest match is written last.
    always_comb begin
        sel_o      = SEL_W'(FWD_RF);
        load_hit_o = 1'b0;
        if (src_used_i && (src_addr_i != '0)) begin
            for (int k = TRACK - 1; k >= 0; k--) begin
                if (slot_valid_i[k] && (slot_waddr_i[k*AW +: AW] == src_addr_i)) begin
                    sel_o      = SEL_W'(k + 1);
                    load_hit_o = slot_load_i[k] && ((k + 1) <= LOAD_LAT);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: EX..WB write scoreboard, load-use stall,
// branch flush, forward selects and saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter  int NUM_STAGES = 5,
    parameter  int REG_AW     = 5,
    parameter  int NUM_SRC    = 2,
    parameter  int LOAD_LAT   = 1,
    parameter  int CNT_W      = 16,
    localparam int TRACK      = NUM_STAGES - 2,
    localparam int SEL_W      = sel_w(TRACK)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]  id_src_addr,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic                       id_wen,
    input  logic [REG_AW-1:0]          id_waddr,
    input  logic                       id_is_load,
    input  logic                       ex_br_taken,
    output logic                       stall,
    output logic                       flush,
    output logic                       pc_en,
    output logic                       ir_en,
    output logic                       npc_en,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic [TRACK-1:0]           stage_valid,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    if (!load_lat_ok(LOAD_LAT, TRACK)) begin : g_bad_load_lat
        $error("pipe_hazard_ctrl: LOAD_LAT must be within 1..TRACK-1");
    end
    if (REG_AW > MAX_AW) begin : g_bad_reg_aw
        $error("pipe_hazard_ctrl: REG_AW exceeds MAX_AW");
    end

    sb_entry_t slot_q [TRACK];
    sb_entry_t slot_d [TRACK];

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [TRACK-1:0]        slot_valid;
    logic [TRACK*MAX_AW-1:0] slot_waddr;
    logic [TRACK-1:0]        slot_load;
    logic [NUM_SRC-1:0]      load_hit;
    logic [NUM_SRC*SEL_W-1:0] sel_raw;

    always_comb begin
        slot_valid = '0;
        slot_waddr = '0;
        slot_load  = '0;
        for (int k = 0; k < TRACK; k++) begin
            slot_valid[k]                   = slot_q[k].valid;
            slot_waddr[k*MAX_AW +: MAX_AW]  = slot_q[k].waddr;
            slot_load[k]                    = slot_q[k].is_load;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_fwd_match #(
            .TRACK    (TRACK),
            .AW       (MAX_AW),
            .SEL_W    (SEL_W),
            .LOAD_LAT (LOAD_LAT)
        ) u_match (
            .src_addr_i   (MAX_AW'(id_src_addr[i*REG_AW +: REG_AW])),
            .src_used_i   (id_src_used[i]),
            .slot_valid_i (slot_valid),
            .slot_waddr_i (slot_waddr),
            .slot_load_i  (slot_load),
            .sel_o        (sel_raw[i*SEL_W +: SEL_W]),
            .load_hit_o   (load_hit[i])
        );
    end

    // A taken branch kills ID anyway, so it overrides any load-use stall.
    assign flush       = ex_br_taken;
    assign stall       = id_valid & ~ex_br_taken & (|load_hit);
    assign pc_en       = ~stall;
    assign ir_en       = ~stall;
    assign npc_en      = ~stall;
    assign fwd_sel     = stall ? '0 : sel_raw;
    assign stage_valid = slot_valid;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    // $0 writes and non-writing instructions never become producers.
    always_comb begin
        slot_d[0]         = '0;
        slot_d[0].valid   = id_valid & ~stall & ~flush & id_wen & (id_waddr != '0);
        slot_d[0].waddr   = MAX_AW'(id_waddr);
        slot_d[0].is_load = id_is_load;
        for (int k = 1; k < TRACK; k++) begin
            slot_d[k] = slot_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TRACK; k++) slot_q[k] <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against
// a list-based model of in-flight producers. A 2-bit-counter copy exercises saturation.
module tb_pipe_hazard_ctrl;

    localparam int AW    = 5;
    localparam int NSRC  = 2;
    localparam int LL    = 1;
    localparam int TRACK = 3;
    localparam int SELW  = 2;
    localparam int CW    = 16;
    localparam int CW2   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                 id_valid, id_wen, id_is_load, ex_br_taken;
    logic [NSRC*AW-1:0]   id_src_addr;
    logic [NSRC-1:0]      id_src_used;
    logic [AW-1:0]        id_waddr;

    logic                 stall, flush, pc_en, ir_en, npc_en;
    logic [NSRC*SELW-1:0] fwd_sel;
    logic [TRACK-1:0]     stage_valid;
    logic [CW-1:0]        stall_cnt, flush_cnt;

    logic                 d2_stall, d2_flush, d2_pc_en, d2_ir_en, d2_npc_en;
    logic [NSRC*SELW-1:0] d2_fwd_sel;
    logic [TRACK-1:0]     d2_stage_valid;
    logic [CW2-1:0]       d2_stall_cnt, d2_flush_cnt;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_wen(id_wen), .id_waddr(id_waddr),
        .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .stall(stall), .flush(flush),
        .pc_en(pc_en), .ir_en(ir_en), .npc_en(npc_en), .fwd_sel(fwd_sel),
        .stage_valid(stage_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(CW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_wen(id_wen), .id_waddr(id_waddr),
        .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .stall(d2_stall), .flush(d2_flush),
        .pc_en(d2_pc_en), .ir_en(d2_ir_en), .npc_en(d2_npc_en), .fwd_sel(d2_fwd_sel),
        .stage_valid(d2_stage_valid), .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: producers in flight, index 1 = EX (youngest) .. TRACK = WB.
    bit mv [1:TRACK];
    int ma [1:TRACK];
    bit ml [1:TRACK];
    int m_sc, m_fc, m_sc2, m_fc2;

    function automatic void m_clear();
        for (int k = 1; k <= TRACK; k++) begin
            mv[k] = 0; ma[k] = 0; ml[k] = 0;
        end
        m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    endfunction

    function automatic int m_win(int i);
        int a;
        a = int'(id_src_addr[i*AW +: AW]);
        if (!id_src_used[i] || a == 0) return 0;
        for (int k = 1; k <= TRACK; k++)
            if (mv[k] && ma[k] == a) return k;
        return 0;
    endfunction

    function automatic bit m_stall();
        int w;
        if (!id_valid || ex_br_taken) return 0;
        for (int i = 0; i < NSRC; i++) begin
            w = m_win(i);
            if (w != 0 && ml[w] && w <= LL) return 1;
        end
        return 0;
    endfunction

    function automatic logic [NSRC*SELW-1:0] m_fwd();
        logic [NSRC*SELW-1:0] v;
        v = '0;
        if (!m_stall())
            for (int i = 0; i < NSRC; i++) v[i*SELW +: SELW] = SELW'(m_win(i));
        return v;
    endfunction

    function automatic logic [TRACK-1:0] m_sv();
        logic [TRACK-1:0] v;
        for (int k = 1; k <= TRACK; k++) v[k-1] = mv[k];
        return v;
    endfunction

    task automatic set_id(bit v, int a0, bit u0, int a1, bit u1, bit wen, int wa, bit ld, bit br);
        id_valid    = v;
        id_src_addr = {AW'(a1), AW'(a0)};
        id_src_used = {u1, u0};
        id_wen      = wen;
        id_waddr    = AW'(wa);
        id_is_load  = ld;
        ex_br_taken = br;
    endtask

    // Clock one cycle: model advances with the inputs present before the edge.
    task automatic adv();
        bit st, fl, ev, el;
        int ea;
        st = m_stall();
        fl = ex_br_taken;
        ev = id_valid && !st && !fl && id_wen && (id_waddr != 0);
        ea = int'(id_waddr);
        el = id_is_load;
        @(posedge clk);
        for (int k = TRACK; k >= 2; k--) begin
            mv[k] = mv[k-1]; ma[k] = ma[k-1]; ml[k] = ml[k-1];
        end
        mv[1] = ev; ma[1] = ea; ml[1] = el;
        if (st) begin
            if (m_sc < (1 << CW) - 1) m_sc++;
            if (m_sc2 < (1 << CW2) - 1) m_sc2++;
        end
        if (fl) begin
            if (m_fc < (1 << CW) - 1) m_fc++;
            if (m_fc2 < (1 << CW2) - 1) m_fc2++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        m_clear();
        #1;
        checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL reset_slots got %b want 000", stage_valid); end
        checks++; if ({stall, flush} !== 2'b00) begin errors++; $display("FAIL reset_stall_flush got %b want 00", {stall, flush}); end
        checks++; if ({pc_en, ir_en, npc_en} !== 3'b111) begin errors++; $display("FAIL reset_enables got %b want 111", {pc_en, ir_en, npc_en}); end
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL reset_fwd got %b want 0000", fwd_sel); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0h/%0h want 0/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // add $3,$1,$2 ; sub $4,$3,$5
    task automatic test_back_to_back();
        set_id(1, 1, 1, 2, 1, 1, 3, 0, 0);
        adv();
        set_id(1, 3, 1, 5, 1, 1, 4, 0, 0);
        #1;
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL b2b_fwd got %b want 0001", fwd_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b want 0", stall); end
        adv();
    endtask

    // lw $8,0($9) ; add $10,$8,$8
    task automatic test_load_use();
        set_id(1, 9, 1, 0, 0, 1, 8, 1, 0);
        adv();
        set_id(1, 8, 1, 8, 1, 1, 10, 0, 0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall); end
        checks++; if ({pc_en, ir_en, npc_en, fwd_sel} !== 7'b000_0000) begin errors++; $display("FAIL lu_en_fwd got %b want 0000000", {pc_en, ir_en, npc_en, fwd_sel}); end
        adv();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b want 0", stall); end
        checks++; if (fwd_sel !== 4'b1010) begin errors++; $display("FAIL lu_fwd got %b want 1010", fwd_sel); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
        adv();
    endtask

    task automatic test_flush();
        set_id(1, 9, 1, 0, 0, 1, 8, 1, 0);
        adv();
        set_id(1, 8, 1, 8, 1, 1, 10, 0, 1);
        #1;
        checks++; if ({flush, stall} !== 2'b10) begin errors++; $display("FAIL fl_over_stall got %b want 10", {flush, stall}); end
        adv();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (stage_valid[0] !== 1'b0) begin errors++; $display("FAIL fl_bubble got %b want 0", stage_valid[0]); end
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL fl_cnt got %0d want 1", flush_cnt); end
    endtask

    // $7 lands in slot 3, a write to $0 in slot 1
    task automatic test_zero_reg();
        set_id(1, 0, 0, 0, 0, 1, 7, 0, 0);
        adv();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        set_id(1, 0, 0, 0, 0, 1, 0, 0, 0);
        adv();
        set_id(1, 0, 1, 7, 1, 0, 0, 0, 0);
        #1;
        checks++; if (fwd_sel !== 4'b1100) begin errors++; $display("FAIL zr_fwd got %b want 1100", fwd_sel); end
        checks++; if (stage_valid !== 3'b100) begin errors++; $display("FAIL zr_slots got %b want 100", stage_valid); end
        adv();
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 5; n++) begin
            set_id(1, 9, 1, 0, 0, 1, 8, 1, 0);
            adv();
            set_id(1, 8, 1, 0, 0, 1, 10, 0, 0);
            adv();
            adv();
        end
        checks++; if (d2_stall_cnt !== 2'b11) begin errors++; $display("FAIL sat_stall got %b want 11", d2_stall_cnt); end
        checks++; if (stall_cnt !== CW'(m_sc)) begin errors++; $display("FAIL sat_stall_wide got %0d want %0d", stall_cnt, m_sc); end
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 5; n++) adv();
        checks++; if (d2_flush_cnt !== 2'b11) begin errors++; $display("FAIL sat_flush got %b want 11", d2_flush_cnt); end
        checks++; if (flush_cnt !== CW'(m_fc)) begin errors++; $display("FAIL sat_flush_wide got %0d want %0d", flush_cnt, m_fc); end
    endtask

    task automatic test_async_reset();
        set_id(1, 0, 0, 0, 0, 1, 1, 0, 0); adv();
        set_id(1, 0, 0, 0, 0, 1, 2, 0, 0); adv();
        set_id(1, 0, 0, 0, 0, 1, 3, 0, 0); adv();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (stage_valid !== 3'b111) begin errors++; $display("FAIL ar_pre got %b want 111", stage_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL ar_slots got %b want 000", stage_valid); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL ar_cnt got %0h/%0h want 0/0", stall_cnt, flush_cnt); end
        m_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit st;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                m_clear();
                checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL rnd_rst got %b want 000", stage_valid); end
                @(negedge clk);
                rst_n = 1'b1;
            end
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            #1;
            st = m_stall();
            checks++; if ({stall, flush} !== {st, ex_br_taken}) begin errors++; $display("FAIL rnd_sf n=%0d got %b want %b", n, {stall, flush}, {st, ex_br_taken}); end
            checks++; if ({pc_en, ir_en, npc_en} !== {3{~st}}) begin errors++; $display("FAIL rnd_en n=%0d got %b want %b", n, {pc_en, ir_en, npc_en}, {3{~st}}); end
            checks++; if (fwd_sel !== m_fwd()) begin errors++; $display("FAIL rnd_fwd n=%0d got %b want %b", n, fwd_sel, m_fwd()); end
            checks++; if (stage_valid !== m_sv()) begin errors++; $display("FAIL rnd_slots n=%0d got %b want %b", n, stage_valid, m_sv()); end
            checks++; if (stall_cnt !== CW'(m_sc) || flush_cnt !== CW'(m_fc)) begin errors++; $display("FAIL rnd_cnt n=%0d got %0d/%0d want %0d/%0d", n, stall_cnt, flush_cnt, m_sc, m_fc); end
            checks++; if ({d2_stall, d2_flush, d2_pc_en, d2_ir_en, d2_npc_en, d2_fwd_sel, d2_stage_valid}
                          !== {st, ex_br_taken, {3{~st}}, m_fwd(), m_sv()}) begin
                errors++; $display("FAIL rnd_d2 n=%0d got %b want %b", n,
                    {d2_stall, d2_flush, d2_pc_en, d2_ir_en, d2_npc_en, d2_fwd_sel, d2_stage_valid},
                    {st, ex_br_taken, {3{~st}}, m_fwd(), m_sv()});
            end
            checks++; if (d2_stall_cnt !== CW2'(m_sc2) || d2_flush_cnt !== CW2'(m_fc2)) begin errors++; $display("FAIL rnd_cnt2 n=%0d got %0d/%0d want %0d/%0d", n, d2_stall_cnt, d2_flush_cnt, m_sc2, m_fc2); end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_reset();
        test_flush();
        test_zero_reg();
        test_saturate();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
